// File: rtl/tug_match_scorer.sv
`default_nettype none
// ============================================================================
// Module   : tug_match_scorer
// Purpose  : Parametrised tug-of-war scorer. Tracks the rope position over
//            SIDE_DEPTH steps per side, applies an optional jump-the-light
//            penalty, counts round wins per player and declares a match
//            winner after ROUNDS_TO_WIN round wins.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SIDE_DEPTH    : rope positions per side, excluding centre (2..15)
//   PENALTY       : step size of a penalised jump-the-light (1..SIDE_DEPTH)
//   ROUNDS_TO_WIN : round wins needed to take the match (1..15)
// Ports
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   winrnd       in   one-cycle pulse: a player pushed
//   right        in   1 = right player pushed first, 0 = left
//   leds_on      in   start light was on at the push (0 = jumped the light)
//   tie          in   simultaneous push, suppresses movement
//   ftl_left     in   enable penalty step when left jumps the light
//   ftl_right    in   enable penalty step when right jumps the light
//   next_round   in   one-cycle pulse: leave a round-win state
//   score        out  display vector, MSB = outermost left position
//   round_over   out  a round has been won, waiting for next_round
//   match_over   out  the match has been won (terminal until rst)
//   winner_right out  side of the last round/match winner (0 = left)
//   rounds_left  out  round wins of the left player
//   rounds_right out  round wins of the right player
// ============================================================================
module tug_match_scorer #(
    parameter int SIDE_DEPTH    = 3,
    parameter int PENALTY       = 2,
    parameter int ROUNDS_TO_WIN = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    winrnd,
    input  logic                    right,
    input  logic                    leds_on,
    input  logic                    tie,
    input  logic                    ftl_left,
    input  logic                    ftl_right,
    input  logic                    next_round,
    output logic [2*SIDE_DEPTH:0]   score,
    output logic                    round_over,
    output logic                    match_over,
    output logic                    winner_right,
    output logic [3:0]              rounds_left,
    output logic [3:0]              rounds_right
);

    // Position register width: signed, must hold +/-(SIDE_DEPTH+1).
    localparam int PW = $clog2(SIDE_DEPTH + 2) + 1;
    // Arithmetic width: two guard bits so pos +/- PENALTY never wraps.
    localparam int AW = PW + 2;
    localparam int SW = 2 * SIDE_DEPTH + 1;

    localparam logic signed [PW-1:0] POS_MAX    = PW'(SIDE_DEPTH + 1);
    localparam logic signed [PW-1:0] POS_MIN    = -POS_MAX;
    localparam logic signed [AW-1:0] LIM_POS    = AW'(SIDE_DEPTH + 1);
    localparam logic signed [AW-1:0] LIM_NEG    = -LIM_POS;
    localparam logic signed [AW-1:0] STEP_ONE   = AW'(1);
    localparam logic signed [AW-1:0] STEP_PEN   = AW'(PENALTY);
    localparam logic [3:0]           ROUNDS_TGT = 4'(ROUNDS_TO_WIN);

    typedef enum logic [2:0] {
        S_RST     = 3'd0,
        S_PLAY    = 3'd1,
        S_WIN_L   = 3'd2,
        S_WIN_R   = 3'd3,
        S_MATCH_L = 3'd4,
        S_MATCH_R = 3'd5
    } state_t;

    state_t                 state;
    logic signed [PW-1:0]   pos;

    // ------------------------------------------------------------------------
    // Candidate move for the current push
    // ------------------------------------------------------------------------
    logic                   move_right;
    logic                   penalised;
    logic signed [AW-1:0]   step;
    logic signed [AW-1:0]   pos_ext;
    logic signed [AW-1:0]   moved;
    logic                   hit_right;
    logic                   hit_left;
    logic [3:0]             rounds_right_inc;
    logic [3:0]             rounds_left_inc;

    always_comb begin
        // A jumped light reverses the direction: the offender pushes the
        // rope toward their opponent.
        move_right       = right ~^ leds_on;
        penalised        = ~leds_on & (right ? ftl_right : ftl_left);
        step             = penalised ? STEP_PEN : STEP_ONE;
        pos_ext          = {{(AW-PW){pos[PW-1]}}, pos};
        moved            = move_right ? (pos_ext + step) : (pos_ext - step);
        hit_right        = (moved >= LIM_POS);
        hit_left         = (moved <= LIM_NEG);
        rounds_right_inc = rounds_right + 4'd1;
        rounds_left_inc  = rounds_left + 4'd1;
    end

    // ------------------------------------------------------------------------
    // State, position and round counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_RST;
            pos          <= '0;
            rounds_left  <= 4'd0;
            rounds_right <= 4'd0;
            winner_right <= 1'b0;
        end else begin
            case (state)
                S_RST: begin
                    // Unconditional: any push on this edge is dropped.
                    state <= S_PLAY;
                    pos   <= '0;
                end

                S_PLAY: begin
                    if (winrnd && !tie) begin
                        if (hit_right) begin
                            pos          <= POS_MAX;
                            winner_right <= 1'b1;
                            rounds_right <= rounds_right_inc;
                            state        <= (rounds_right_inc == ROUNDS_TGT)
                                            ? S_MATCH_R : S_WIN_R;
                        end else if (hit_left) begin
                            pos          <= POS_MIN;
                            winner_right <= 1'b0;
                            rounds_left  <= rounds_left_inc;
                            state        <= (rounds_left_inc == ROUNDS_TGT)
                                            ? S_MATCH_L : S_WIN_L;
                        end else begin
                            pos <= moved[PW-1:0];
                        end
                    end
                end

                S_WIN_L, S_WIN_R: begin
                    if (next_round) begin
                        state <= S_PLAY;
                        pos   <= '0;
                    end
                end

                S_MATCH_L, S_MATCH_R: begin
                    // Terminal until reset.
                    state <= state;
                end

                default: begin
                    state <= S_RST;
                    pos   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode (registered state only)
    // ------------------------------------------------------------------------
    always_comb begin
        score = '0;
        case (state)
            S_RST: begin
                score[SW-1] = 1'b1;
                score[SW-2] = 1'b1;
                score[1]    = 1'b1;
                score[0]    = 1'b1;
            end
            S_PLAY: begin
                for (int i = 0; i < SW; i++) begin
                    score[i] = (i == (SIDE_DEPTH - int'(pos)));
                end
            end
            S_WIN_L, S_MATCH_L: begin
                for (int i = 0; i < SW; i++) begin
                    score[i] = (i > SIDE_DEPTH);
                end
            end
            S_WIN_R, S_MATCH_R: begin
                for (int i = 0; i < SW; i++) begin
                    score[i] = (i < SIDE_DEPTH);
                end
            end
            default: begin
                // The MSB index is even, so 1010... from the MSB sets even bits.
                for (int i = 0; i < SW; i++) begin
                    score[i] = ((i % 2) == 0);
                end
            end
        endcase
    end

    assign round_over = (state == S_WIN_L)   || (state == S_WIN_R);
    assign match_over = (state == S_MATCH_L) || (state == S_MATCH_R);

endmodule
`default_nettype wire

// File: tb/tb_tug_match_scorer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tug_match_scorer
// Purpose  : Self-checking bench for tug_match_scorer (default parameters).
//            Directed vector table plus randomized traffic against a
//            position/round reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tug_match_scorer;

    localparam int D   = 3;
    localparam int PEN = 2;
    localparam int RTW = 2;
    localparam int SW  = 2 * D + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           winrnd, right, leds_on, tie, ftl_left, ftl_right, next_round;
    logic [SW-1:0]  score;
    logic           round_over, match_over, winner_right;
    logic [3:0]     rounds_left, rounds_right;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tug_match_scorer #(
        .SIDE_DEPTH    (D),
        .PENALTY       (PEN),
        .ROUNDS_TO_WIN (RTW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .winrnd       (winrnd),
        .right        (right),
        .leds_on      (leds_on),
        .tie          (tie),
        .ftl_left     (ftl_left),
        .ftl_right    (ftl_right),
        .next_round   (next_round),
        .score        (score),
        .round_over   (round_over),
        .match_over   (match_over),
        .winner_right (winner_right),
        .rounds_left  (rounds_left),
        .rounds_right (rounds_right)
    );

    // ------------------------------------------------------------------------
    // Comparison helpers
    // ------------------------------------------------------------------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [SW-1:0] es,
                                 input bit ro, input bit mo, input bit wr,
                                 input int rl, input int rr);
        cmp({tag, ".score"},        32'(score),        32'(es));
        cmp({tag, ".round_over"},   32'(round_over),   32'(ro));
        cmp({tag, ".match_over"},   32'(match_over),   32'(mo));
        cmp({tag, ".winner_right"}, 32'(winner_right), 32'(wr));
        cmp({tag, ".rounds_left"},  32'(rounds_left),  32'(rl));
        cmp({tag, ".rounds_right"}, 32'(rounds_right), 32'(rr));
    endtask

    // ------------------------------------------------------------------------
    // Reference model: 0 RST, 1 PLAY, 2 WIN_L, 3 WIN_R, 4 MATCH_L, 5 MATCH_R
    // ------------------------------------------------------------------------
    int m_st, m_pos, m_rl, m_rr;
    bit m_wr;

    function automatic void m_reset();
        m_st = 0; m_pos = 0; m_rl = 0; m_rr = 0; m_wr = 0;
    endfunction

    function automatic void m_edge(bit w, bit r, bit l, bit t, bit fl, bit fr, bit nr);
        int dir;
        int sz;
        case (m_st)
            0: begin m_st = 1; m_pos = 0; end
            1: begin
                if (w && !t) begin
                    dir   = (r == l) ? 1 : -1;
                    sz    = (!l && (r ? fr : fl)) ? PEN : 1;
                    m_pos = m_pos + dir * sz;
                    if (m_pos >= D + 1) begin
                        m_rr++; m_wr = 1;
                        m_st = (m_rr == RTW) ? 5 : 3;
                    end else if (m_pos <= -(D + 1)) begin
                        m_rl++; m_wr = 0;
                        m_st = (m_rl == RTW) ? 4 : 2;
                    end
                end
            end
            2, 3: if (nr) begin m_st = 1; m_pos = 0; end
            default: ;
        endcase
    endfunction

    function automatic logic [SW-1:0] m_score();
        logic [SW-1:0] s;
        s = '0;
        case (m_st)
            0: begin s[SW-1] = 1; s[SW-2] = 1; s[1] = 1; s[0] = 1; end
            1: s[D - m_pos] = 1'b1;
            2, 4: for (int i = D + 1; i < SW; i++) s[i] = 1'b1;
            default: for (int i = 0; i < D; i++) s[i] = 1'b1;
        endcase
        return s;
    endfunction

    task automatic check_model(input string tag);
        check_outputs(tag, m_score(), (m_st == 2) || (m_st == 3),
                      (m_st == 4) || (m_st == 5), m_wr, m_rl, m_rr);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic apply(input bit w, input bit r, input bit l, input bit t,
                         input bit fl, input bit fr, input bit nr);
        winrnd = w; right = r; leds_on = l; tie = t;
        ftl_left = fl; ftl_right = fr; next_round = nr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit             arst;
        bit             w, r, l, t, fl, fr, nr;
        logic [SW-1:0]  e_score;
        bit             e_ro, e_mo, e_wr;
        int             e_rl, e_rr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit ar, bit w, bit r, bit l, bit t, bit fl, bit fr, bit nr,
                                logic [SW-1:0] s, bit ro, bit mo, bit wr, int rl, int rr);
        vec_t v;
        v.arst = ar; v.w = w; v.r = r; v.l = l; v.t = t; v.fl = fl; v.fr = fr; v.nr = nr;
        v.e_score = s; v.e_ro = ro; v.e_mo = mo; v.e_wr = wr; v.e_rl = rl; v.e_rr = rr;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1;
        winrnd = 0; right = 0; leds_on = 0; tie = 0;
        ftl_left = 0; ftl_right = 0; next_round = 0;

        //   ar w r l t fl fr nr  score        ro mo wr rl rr
        add(0, 1,1,1,0,0,0,0, 7'b0001000, 0,0,0, 0,0); // RST->PLAY, push ignored
        add(0, 1,1,1,0,0,0,0, 7'b0000100, 0,0,0, 0,0);
        add(0, 1,1,1,0,0,0,0, 7'b0000010, 0,0,0, 0,0);
        add(0, 1,1,1,0,0,0,0, 7'b0000001, 0,0,0, 0,0);
        add(0, 1,1,1,0,0,0,0, 7'b0000111, 1,0,1, 0,1); // right round win
        add(0, 1,0,1,0,0,0,0, 7'b0000111, 1,0,1, 0,1); // push ignored in WIN
        add(0, 0,0,0,0,0,0,1, 7'b0001000, 0,0,1, 0,1); // next_round
        add(0, 1,0,0,0,1,0,0, 7'b0000010, 0,0,1, 0,1); // left jumps, penalised
        add(0, 1,0,1,0,0,0,0, 7'b0000100, 0,0,1, 0,1); // left normal push
        add(0, 1,0,0,0,0,0,0, 7'b0000010, 0,0,1, 0,1); // left jumps, no penalty
        add(0, 1,1,1,1,0,0,0, 7'b0000010, 0,0,1, 0,1); // tie blocks move
        add(0, 1,0,0,0,1,0,0, 7'b0000111, 0,1,1, 0,2); // +2 -> +4, match right
        add(0, 0,0,0,0,0,0,1, 7'b0000111, 0,1,1, 0,2); // next_round ignored
        add(0, 1,0,1,0,0,0,0, 7'b0000111, 0,1,1, 0,2); // push ignored
        add(1, 0,0,0,0,0,0,0, 7'b1100011, 0,0,0, 0,0); // async reset mid-match
        add(0, 1,0,1,0,0,0,0, 7'b0001000, 0,0,0, 0,0); // RST->PLAY, push ignored
        add(0, 1,0,1,0,0,0,0, 7'b0010000, 0,0,0, 0,0);
        add(0, 1,0,1,0,0,0,0, 7'b0100000, 0,0,0, 0,0);
        add(0, 1,0,1,1,0,0,0, 7'b0100000, 0,0,0, 0,0); // tie at -2
        add(0, 0,0,1,0,0,0,1, 7'b0100000, 0,0,0, 0,0); // next_round ignored in PLAY
        add(0, 1,1,0,0,0,1,0, 7'b1110000, 1,0,0, 1,0); // right jumps, -4: left win
        add(0, 0,0,0,0,0,0,1, 7'b0001000, 0,0,0, 1,0);
        add(0, 1,1,0,0,0,0,0, 7'b0010000, 0,0,0, 1,0); // right jumps, no penalty
        add(0, 1,1,1,0,0,0,0, 7'b0001000, 0,0,0, 1,0);

        // Reset pattern while held and after release, before the first edge.
        @(posedge clk);
        #1;
        check_outputs("rst_hold", 7'b1100011, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check_outputs("rst_release", 7'b1100011, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            if (vecs[i].arst) begin
                rst = 1'b1;
                #1;
                check_outputs($sformatf("vec%0d", i), vecs[i].e_score, vecs[i].e_ro,
                              vecs[i].e_mo, vecs[i].e_wr, vecs[i].e_rl, vecs[i].e_rr);
                rst = 1'b0;
            end else begin
                apply(vecs[i].w, vecs[i].r, vecs[i].l, vecs[i].t,
                      vecs[i].fl, vecs[i].fr, vecs[i].nr);
                check_outputs($sformatf("vec%0d", i), vecs[i].e_score, vecs[i].e_ro,
                              vecs[i].e_mo, vecs[i].e_wr, vecs[i].e_rl, vecs[i].e_rr);
            end
        end

        // Randomized traffic against the model, with occasional async resets.
        rst = 1'b1;
        #1;
        m_reset();
        check_model("rnd_start");
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                #1;
                m_reset();
                check_model($sformatf("rnd%0d_arst", n));
                rst = 1'b0;
            end else begin
                bit w, r, l, t, fl, fr, nr;
                w  = 1'($urandom_range(0, 1));
                r  = 1'($urandom_range(0, 1));
                l  = 1'($urandom_range(0, 1));
                t  = ($urandom_range(0, 7) == 0);
                fl = 1'($urandom_range(0, 1));
                fr = 1'($urandom_range(0, 1));
                nr = ($urandom_range(0, 5) == 0);
                apply(w, r, l, t, fl, fr, nr);
                m_edge(w, r, l, t, fl, fr, nr);
                check_model($sformatf("rnd%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
